// File: rtl/aes_out_serializer_pkg.sv
// Shared AES output-path constants: block geometry and serializer FSM encoding.
package aes_out_serializer_pkg;

  localparam int AES_BLOCK_BYTES = 16;
  localparam int AES_BYTE_W      = 8;
  localparam int AES_BLOCK_W     = AES_BLOCK_BYTES * AES_BYTE_W;

  typedef logic [AES_BLOCK_W-1:0] aes_block_t;
  typedef logic [AES_BYTE_W-1:0]  aes_byte_t;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SEND = 1'b1;

endpackage

// File: rtl/aes_out_serializer_if.sv
// Bundle of the finished-block input slot and the byte-stream output handshake.
interface aes_out_serializer_if;
  import aes_out_serializer_pkg::*;

  logic      empty_in;
  aes_byte_t in0, in1, in2, in3, in4, in5, in6, in7;
  aes_byte_t in8, in9, inA, inB, inC, inD, inE, inF;
  aes_byte_t out_byte;
  logic      out_valid;
  logic      out_ready;
  logic      out_last;
  logic      overflow;

  modport master (
    output empty_in, in0, in1, in2, in3, in4, in5, in6, in7,
           in8, in9, inA, inB, inC, inD, inE, inF, out_ready,
    input  out_byte, out_valid, out_last, overflow
  );

  modport slave (
    input  empty_in, in0, in1, in2, in3, in4, in5, in6, in7,
           in8, in9, inA, inB, inC, inD, inE, inF, out_ready,
    output out_byte, out_valid, out_last, overflow
  );

endinterface

// File: rtl/aes_ser_mux16.sv
// Combinational 16:1 byte select out of one packed 128-bit block (byte k at bits [8k+7:8k]).
module aes_ser_mux16 #(
  parameter int DATA_W = 8
) (
  input  logic [16*DATA_W-1:0] blk,
  input  logic [3:0]           sel,
  output logic [DATA_W-1:0]    data_out
);

  assign data_out = blk[sel*DATA_W +: DATA_W];

endmodule

// File: rtl/aes_out_serializer.sv
// Two-entry block buffer that serializes finished AES blocks into a ready/valid byte stream.
// Optional macro AES_SER_DROP_CNT_EN adds a saturating drop_cnt output.
module aes_out_serializer
  import aes_out_serializer_pkg::*;
#(
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic                 clock,
  input  logic                 reset,
  aes_out_serializer_if.slave  bus
`ifdef AES_SER_DROP_CNT_EN
  ,
  output logic [7:0]           drop_cnt
`endif
);

  aes_block_t  blk_mem [2];
  aes_block_t  blk_in;
  logic [1:0]  count;
  logic [1:0]  count_next;
  logic        wr_ptr;
  logic        rd_ptr;
  logic [3:0]  idx;
  logic [3:0]  sel;
  logic [0:0]  state;
  logic [0:0]  state_next;
  logic        ovf;
  logic        xfer;
  logic        last_xfer;
  logic        free;
  logic        capture;
  logic        drop;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign blk_in = {bus.inF, bus.inE, bus.inD, bus.inC, bus.inB, bus.inA, bus.in9, bus.in8,
                   bus.in7, bus.in6, bus.in5, bus.in4, bus.in3, bus.in2, bus.in1, bus.in0};

  // Handshake and free-slot decode; a slot frees up when the final byte leaves this cycle
  always_comb begin
    xfer       = bus.out_valid & bus.out_ready;
    last_xfer  = xfer & (idx == 4'hF);
    free       = (count != 2'd2) | last_xfer;
    capture    = ~bus.empty_in & free;
    drop       = ~bus.empty_in & ~free;
    count_next = count + {1'b0, capture} - {1'b0, last_xfer};
  end

  // Next-state logic: SEND whenever at least one block is held
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (capture) state_next = ST_SEND;
      ST_SEND: if (last_xfer && !capture && count == 2'd1) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Block storage is data only, so it is never cleared by reset
  always_ff @(posedge clock) begin
    if (capture) blk_mem[wr_ptr] <= blk_in;
  end

  // Control state: pointers, occupancy, byte index, sticky overflow
  always_ff @(posedge clock) begin
    if (reset) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      idx    <= 4'd0;
      ovf    <= 1'b0;
      state  <= ST_IDLE;
    end else begin
      if (capture)   wr_ptr <= ~wr_ptr;
      if (last_xfer) rd_ptr <= ~rd_ptr;
      if (xfer)      idx    <= idx + 4'd1;
      if (drop)      ovf    <= 1'b1;
      count <= count_next;
      state <= state_next;
    end
  end

`ifdef AES_SER_DROP_CNT_EN
  // Saturating count of discarded blocks
  always_ff @(posedge clock) begin
    if (reset)     drop_cnt <= 8'd0;
    else if (drop) drop_cnt <= sat_inc8(drop_cnt);
  end
`endif

  // Byte order: reversed index walks inF down to in0
  assign sel = LSB_FIRST ? ~idx : idx;

  aes_ser_mux16 #(.DATA_W(AES_BYTE_W)) u_mux (
    .blk      (blk_mem[rd_ptr]),
    .sel      (sel),
    .data_out (bus.out_byte)
  );

  assign bus.out_valid = (state == ST_SEND);
  assign bus.out_last  = bus.out_valid & (idx == 4'hF);
  assign bus.overflow  = ovf;

endmodule

// File: tb/tb_aes_out_serializer.sv
// Directed table-driven bench for aes_out_serializer (MSB-order instance) plus an LSB_FIRST instance.
module tb_aes_out_serializer;

  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  aes_out_serializer_if bus0();
  aes_out_serializer_if bus1();

`ifdef AES_SER_DROP_CNT_EN
  logic [7:0] drop_cnt0, drop_cnt1;
`endif

  aes_out_serializer #(.LSB_FIRST(1'b0)) dut0 (
    .clock    (clock),
    .reset    (reset),
    .bus      (bus0)
`ifdef AES_SER_DROP_CNT_EN
    ,
    .drop_cnt (drop_cnt0)
`endif
  );

  aes_out_serializer #(.LSB_FIRST(1'b1)) dut1 (
    .clock    (clock),
    .reset    (reset),
    .bus      (bus1)
`ifdef AES_SER_DROP_CNT_EN
    ,
    .drop_cnt (drop_cnt1)
`endif
  );

  typedef struct {
    logic       rst;
    logic       empty;
    logic [7:0] base;
    logic       rdy;
    logic       chk;
    logic       ev;
    logic [7:0] eb;
    logic       el;
    logic       eo;
    logic [7:0] ed;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic add(input logic r, input logic e, input logic [7:0] base, input logic rdy,
                     input logic chk, input logic ev, input logic [7:0] eb, input logic el,
                     input logic eo, input logic [7:0] ed);
    vec_t v;
    v.rst = r; v.empty = e; v.base = base; v.rdy = rdy; v.chk = chk;
    v.ev = ev; v.eb = eb; v.el = el; v.eo = eo; v.ed = ed;
    vecs.push_back(v);
  endtask

  // Bytes k0..k1 of a block whose byte k is base+k, presented with ready=1 and no new input
  task automatic add_run(input logic [7:0] base, input int k0, input int k1,
                         input logic eo, input logic [7:0] ed);
    for (int k = k0; k <= k1; k++)
      add(1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 1'b1, base + 8'(k), (k == 15), eo, ed);
  endtask

  task automatic drive(input logic r, input logic e, input logic [7:0] base, input logic rdy);
    reset = r;
    bus0.empty_in = e; bus1.empty_in = e;
    bus0.out_ready = rdy; bus1.out_ready = rdy;
    bus0.in0 = base;        bus1.in0 = base;
    bus0.in1 = base + 8'd1; bus1.in1 = base + 8'd1;
    bus0.in2 = base + 8'd2; bus1.in2 = base + 8'd2;
    bus0.in3 = base + 8'd3; bus1.in3 = base + 8'd3;
    bus0.in4 = base + 8'd4; bus1.in4 = base + 8'd4;
    bus0.in5 = base + 8'd5; bus1.in5 = base + 8'd5;
    bus0.in6 = base + 8'd6; bus1.in6 = base + 8'd6;
    bus0.in7 = base + 8'd7; bus1.in7 = base + 8'd7;
    bus0.in8 = base + 8'd8; bus1.in8 = base + 8'd8;
    bus0.in9 = base + 8'd9; bus1.in9 = base + 8'd9;
    bus0.inA = base + 8'd10; bus1.inA = base + 8'd10;
    bus0.inB = base + 8'd11; bus1.inB = base + 8'd11;
    bus0.inC = base + 8'd12; bus1.inC = base + 8'd12;
    bus0.inD = base + 8'd13; bus1.inD = base + 8'd13;
    bus0.inE = base + 8'd14; bus1.inE = base + 8'd14;
    bus0.inF = base + 8'd15; bus1.inF = base + 8'd15;
  endtask

  task automatic cmp(input string name, input int row, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s row %0d: got %h, expected %h", name, row, act, exp);
    end
  endtask

  initial begin
    drive(1'b1, 1'b1, 8'h00, 1'b0);

    // Reset, then reset-state check
    add(1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    add(1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);

    // Single block 00..0F
    add(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    add_run(8'h00, 0, 15, 1'b0, 8'h00);
    add(1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);

    // Backpressure: ready alternates 0/1, byte held during each stall
    add(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    for (int k = 0; k < 16; k++) begin
      add(1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 8'(k), (k == 15), 1'b0, 8'h00);
      add(1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 1'b1, 8'(k), (k == 15), 1'b0, 8'h00);
    end
    add(1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);

    // Overflow: A=20.., B=40.., C=60.. back-to-back while stalled; C dropped
    add(1'b0, 1'b0, 8'h20, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    add(1'b0, 1'b0, 8'h40, 1'b0, 1'b1, 1'b1, 8'h20, 1'b0, 1'b0, 8'h00);
    add(1'b0, 1'b0, 8'h60, 1'b0, 1'b1, 1'b1, 8'h20, 1'b0, 1'b0, 8'h00);
    add(1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 8'h20, 1'b0, 1'b1, 8'h01);
    add_run(8'h20, 0, 15, 1'b1, 8'h01);
    add_run(8'h40, 0, 15, 1'b1, 8'h01);
    add(1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h01);
    add(1'b1, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h01);

    // Simultaneous: D=80.. arrives with the last byte of A while full
    add(1'b0, 1'b0, 8'h20, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    add(1'b0, 1'b0, 8'h40, 1'b0, 1'b1, 1'b1, 8'h20, 1'b0, 1'b0, 8'h00);
    add_run(8'h20, 0, 14, 1'b0, 8'h00);
    add(1'b0, 1'b0, 8'h80, 1'b1, 1'b1, 1'b1, 8'h2F, 1'b1, 1'b0, 8'h00);
    add_run(8'h40, 0, 15, 1'b0, 8'h00);
    add_run(8'h80, 0, 15, 1'b0, 8'h00);
    add(1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);

    // Reset mid-block (also beats a capture and a transfer on that edge)
    add(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    add_run(8'h00, 0, 4, 1'b0, 8'h00);
    add(1'b1, 1'b0, 8'h60, 1'b1, 1'b1, 1'b1, 8'h05, 1'b0, 1'b0, 8'h00);
    add(1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    add(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    add_run(8'h00, 0, 15, 1'b0, 8'h00);
    add(1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);

    // Apply: inputs change at negedge, outputs compared 1 time unit later
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clock);
      drive(vecs[i].rst, vecs[i].empty, vecs[i].base, vecs[i].rdy);
      #1;
      if (vecs[i].chk) begin
        cmp("out_valid", i, {7'd0, bus0.out_valid}, {7'd0, vecs[i].ev});
        cmp("out_last",  i, {7'd0, bus0.out_last},  {7'd0, vecs[i].el});
        cmp("overflow",  i, {7'd0, bus0.overflow},  {7'd0, vecs[i].eo});
        if (vecs[i].ev) cmp("out_byte", i, bus0.out_byte, vecs[i].eb);
`ifdef AES_SER_DROP_CNT_EN
        cmp("drop_cnt", i, drop_cnt0, vecs[i].ed);
`endif
      end
    end

    // LSB_FIRST instance: block 00..0F must leave as 0F down to 00
    @(negedge clock); drive(1'b1, 1'b1, 8'h00, 1'b1);
    @(negedge clock); drive(1'b0, 1'b0, 8'h00, 1'b1);
    #1;
    cmp("lsb_valid_idle", 1000, {7'd0, bus1.out_valid}, 8'd0);
    for (int k = 0; k < 16; k++) begin
      @(negedge clock); drive(1'b0, 1'b1, 8'h00, 1'b1);
      #1;
      cmp("lsb_valid", 1001 + k, {7'd0, bus1.out_valid}, 8'd1);
      cmp("lsb_byte",  1001 + k, bus1.out_byte, 8'h0F - 8'(k));
      cmp("lsb_last",  1001 + k, {7'd0, bus1.out_last}, {7'd0, (k == 15)});
    end
    @(negedge clock); drive(1'b0, 1'b1, 8'h00, 1'b1);
    #1;
    cmp("lsb_valid_done", 1017, {7'd0, bus1.out_valid}, 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
